// File: rtl/board_store.sv
// Chess-board piece store: LOAD/WRITE/CLEAR_ALL/MOVE commands over a
// valid/ready port, a registered square query and a packed board bus.
module board_store #(
  parameter int SQUARES = 64,
  parameter int PIECE_W = 4,
  parameter int SQ_W    = $clog2(SQUARES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [SQ_W-1:0]              cmd_from,
  input  logic [SQ_W-1:0]              cmd_to,
  input  logic [PIECE_W-1:0]           cmd_piece,
  input  logic [SQUARES*PIECE_W-1:0]   load_board,
  output logic                         done,
  output logic                         err,
  output logic [PIECE_W-1:0]           captured,
  input  logic [SQ_W-1:0]              rd_sq,
  output logic [PIECE_W-1:0]           rd_piece,
  output logic [SQUARES*PIECE_W-1:0]   board_out
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [SQ_W:0] SQ_LIM = (SQ_W+1)'(SQUARES);

  state_t               state_q;
  logic [PIECE_W-1:0]   brd_q [SQUARES];
  logic [SQ_W-1:0]      from_q;
  logic [SQ_W-1:0]      to_q;
  logic                 done_q;
  logic                 err_q;
  logic [PIECE_W-1:0]   cap_q;
  logic [PIECE_W-1:0]   rd_q;

  logic                 wr_ok;
  logic                 rd_ok;
  logic                 from_ok;
  logic                 to_ok;
  logic [PIECE_W-1:0]   src_d;
  logic [PIECE_W-1:0]   dst_d;
  logic [PIECE_W-1:0]   rd_d;
  logic                 mv_err_d;
  logic                 is_wr;
  logic                 is_mv;
  logic                 is_ld;
  logic                 is_clr;

  assign is_wr  = (cmd_op == 2'b00);
  assign is_mv  = (cmd_op == 2'b01);
  assign is_ld  = (cmd_op == 2'b10);
  assign is_clr = (cmd_op == 2'b11);

  assign wr_ok   = {1'b0, cmd_to} < SQ_LIM;
  assign rd_ok   = {1'b0, rd_sq}  < SQ_LIM;
  assign from_ok = {1'b0, from_q} < SQ_LIM;
  assign to_ok   = {1'b0, to_q}   < SQ_LIM;

  // Out-of-range indices are masked so they never read stray storage.
  always_comb begin
    src_d = '0;
    dst_d = '0;
    rd_d  = '0;
    if (from_ok) src_d = brd_q[from_q];
    if (to_ok)   dst_d = brd_q[to_q];
    if (rd_ok)   rd_d  = brd_q[rd_sq];
    mv_err_d = !from_ok || !to_ok || (src_d == '0);
  end

  always_comb begin
    board_out = '0;
    for (int i = 0; i < SQUARES; i++)
      board_out[i*PIECE_W +: PIECE_W] = brd_q[i];
  end

  assign cmd_ready = (state_q == IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign captured  = cap_q;
  assign rd_piece  = rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      from_q  <= '0;
      to_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cap_q   <= '0;
      rd_q    <= '0;
      for (int i = 0; i < SQUARES; i++)
        brd_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      rd_q   <= rd_d;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            unique case (1'b1)
              is_wr: begin
                done_q <= 1'b1;
                err_q  <= !wr_ok;
                cap_q  <= '0;
                if (wr_ok) brd_q[cmd_to] <= cmd_piece;
              end
              is_mv: begin
                from_q  <= cmd_from;
                to_q    <= cmd_to;
                state_q <= EXEC;
              end
              is_ld: begin
                done_q <= 1'b1;
                err_q  <= 1'b0;
                cap_q  <= '0;
                for (int i = 0; i < SQUARES; i++)
                  brd_q[i] <= load_board[i*PIECE_W +: PIECE_W];
              end
              is_clr: begin
                done_q <= 1'b1;
                err_q  <= 1'b0;
                cap_q  <= '0;
                for (int i = 0; i < SQUARES; i++)
                  brd_q[i] <= '0;
              end
              default: ;
            endcase
          end
        end
        EXEC: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          err_q   <= mv_err_d;
          cap_q   <= '0;
          // A self-move of a real piece is a legal no-op.
          if (!mv_err_d && (from_q != to_q)) begin
            cap_q         <= dst_d;
            brd_q[to_q]   <= src_d;
            brd_q[from_q] <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/board_store.md
# board_store

Registered chess-board state memory with a command port. It holds SQUARES piece codes of PIECE_W bits each and executes whole-board load, single-square write, clear-all and from→to move commands through a valid/ready handshake. Moves report the captured piece and an error flag. A registered single-square query port and a continuously driven packed board bus serve the move-legality, display and game-control logic.

## Interface
Parameters:
- SQUARES, 64, number of squares; any value 2..256.
- PIECE_W, 4, bits per piece code; code 0 = empty.
- SQ_W, $clog2(SQUARES), square-index width; derived, not overridden.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block accepts a command this cycle.
- cmd_op  in  2  00 WRITE, 01 MOVE, 10 LOAD, 11 CLEAR_ALL.
- cmd_from  in  SQ_W  MOVE source square.
- cmd_to  in  SQ_W  MOVE destination square; WRITE target square.
- cmd_piece  in  PIECE_W  WRITE data.
- load_board  in  SQUARES*PIECE_W  LOAD data; square k at bits [k*PIECE_W +: PIECE_W].
- done  out  1  one-cycle pulse: command finished.
- err  out  1  valid with done: command rejected, board unchanged.
- captured  out  PIECE_W  valid with done: prior content of the MOVE destination, else 0.
- rd_sq  in  SQ_W  query square.
- rd_piece  out  PIECE_W  registered content of rd_sq.
- board_out  out  SQUARES*PIECE_W  current board, packed like load_board.

## Operation
- States: IDLE, EXEC. cmd_ready = (state == IDLE).
- Accept on the rising edge where cmd_valid && cmd_ready. WRITE, LOAD and CLEAR_ALL complete on the accepting edge. The state stays IDLE.
- WRITE: square cmd_to ← cmd_piece.
- LOAD: all squares ← load_board.
- CLEAR_ALL: all squares ← 0.
- MOVE: the accepting edge latches from/to and enters EXEC. On the next edge:
  - captured ← board[to], board[to] ← board[from], board[from] ← 0.
  - State returns to IDLE.
- MOVE errors (err=1, board unchanged, captured=0):
  - board[from] == 0 (empty source).
  - from or to ≥ SQUARES.
- WRITE with cmd_to ≥ SQUARES: err=1, no change.
- MOVE with from == to and a non-empty source: no change, err=0, captured=0.
- Captured pieces are not checked for colour; legality is the caller's concern.
- Query port: rd_piece ← board[rd_sq] every edge, using the pre-update board. rd_sq ≥ SQUARES returns 0.
- board_out is driven directly from the board registers, with no extra delay.

## Timing
- Reset (async assert, sync-safe deassert): all squares 0, state IDLE.
- Outputs during reset: cmd_ready=1, done=0, err=0, captured=0, rd_piece=0, board_out=0.
- Reset asserted in EXEC aborts the move. No done pulse is produced, and the board is cleared.
- Single-edge ops (WRITE, LOAD, CLEAR_ALL) accepted at edge E0:
  - done/err are high in the cycle after E0.
  - board_out shows the new value in that same cycle.
- MOVE accepted at E0:
  - cmd_ready=0 in the cycle after E0; the update happens at E1.
  - done/err/captured are valid in the cycle after E1, with cmd_ready=1 again.
  - Throughput: one MOVE per 2 cycles. Other ops: 1 per cycle.
- done is a one-cycle pulse. captured and err hold their value until the next done.
- A query in the same cycle as an update edge returns the old value; the new value is visible one cycle later.

## Test plan
- Reset with defaults -> board_out=0, cmd_ready=1, done=0, rd_piece=0 for every rd_sq.
- WRITE sq 12 = 0x6, then query rd_sq=12 -> done pulse with err=0; rd_piece=0x6 one cycle after the query; board_out[51:48]=0x6.
- LOAD the standard start position, then MOVE 12→28 -> cmd_ready low 1 cycle; afterwards captured=0, board[28]=old board[12], board[12]=0.
- Square 51 holds 0xE; MOVE 28→51 -> captured=0xE, board[51]=the piece moved from 28, board[28]=0.
- MOVE from an empty square 20→36 -> err=1, captured=0, board_out unchanged. With SQUARES=48, MOVE 5→50 -> err=1.
- Accept a MOVE, then assert rst_n=0 in EXEC -> no done pulse; board_out=0 and cmd_ready=1 immediately. Back-to-back WRITEs accepted on consecutive cycles -> two done pulses.
